sprite_collision_detector: RTL and testbench
============================================

Name: sprite_collision_detector

Overview:
- Sits directly downstream of the mask-sprite renderers.
- Consumes the 1-bit draw masks of the player sprite and the obstacle sprite, which are pipelined SPRITE_LATENCY cycles behind the raw hcount/vcount.
- Counts per-frame pixel overlap and raises a sticky collision flag, with hit coordinates, for the game FSM.
- Evaluates only complete frames.

Parameters:
- SPRITE_LATENCY, 4: cycles from hcount_in/vcount_in to valid draw masks.
- H_ACTIVE, 1280: active pixels per line.
- V_ACTIVE, 720: active lines per frame.
- MIN_OVERLAP, 4: overlapping pixels in one frame needed to declare a collision (1..65535).

Ports:
- pixel_clk_in  in  1  pixel clock.
- rst_n_in  in  1  reset, asynchronous assert, active-low.
- hcount_in  in  11  raw horizontal count.
- vcount_in  in  10  raw vertical count.
- player_draw_in  in  1  player mask, SPRITE_LATENCY behind the counts.
- obstacle_draw_in  in  1  obstacle mask, same latency.
- enable_in  in  1  detection enable, sampled with the masks.
- clear_in  in  1  game FSM acknowledge/clear.
- collision_out  out  1  sticky collision flag.
- frame_done_out  out  1  1-cycle pulse per evaluated frame.
- overlap_count_out  out  16  overlap count of the last evaluated frame.
- hit_x_out  out  11  x of the first overlap pixel in the colliding frame.
- hit_y_out  out  10  y of the first overlap pixel in the colliding frame.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. All outputs are 0, the state is ARMED, and the delay line and its valid bits are cleared.
- Delay line: hcount/vcount are delayed SPRITE_LATENCY cycles, producing dh/dv. A parallel valid shift register fills with 1s after reset. dh/dv are ignored until the valid bit reaches the end, so zeroed registers never look like a frame start.
- active = valid && dh < H_ACTIVE && dv < V_ACTIVE.
- ovl = active && enable_in && player_draw_in && obstacle_draw_in.
- first = valid && dh==0 && dv==0.
- last = valid && dh==H_ACTIVE-1 && dv==V_ACTIVE-1.
- ARMED:
  - Waits for first. On first, go to SCAN; the first pixel itself is counted (count <= ovl).
  - Reset or clear landing mid-frame leaves the block in ARMED, so partial frames are never evaluated.
- SCAN:
  - On each ovl, the 16-bit count increments, saturating at 0xFFFF.
  - On the first ovl of the frame, capture dh/dv into hit regs.
  - On last, the last pixel's ovl is included; go to REPORT.
  - Overlaps in blanking are ignored.
- REPORT (exactly 1 cycle):
  - frame_done_out=1 and overlap_count_out=count.
  - If count>=MIN_OVERLAP: collision_out=1, hit_x_out/hit_y_out take the hit regs, next state LOCKED.
  - Otherwise: collision_out stays 0, hit outputs unchanged, next state ARMED.
  - The count is cleared on exit.
- LOCKED:
  - collision_out and the hit outputs are held, and no counting occurs.
  - clear_in leads to ARMED on the next cycle, with collision_out=0 in that same transition.
- clear_in in SCAN or REPORT:
  - Abort: go to ARMED and discard the count and hit regs.
  - frame_done_out is suppressed, and outputs keep their previous values.
  - clear_in has priority over last.
- clear_in in ARMED has no effect.
- All outputs are registered.
- Latency: last pixel seen at cycle N gives frame_done_out and collision_out at cycle N+1.

Optional Feature:
- Macro: COLLISION_BBOX_EN.
- When defined, the block adds ports hit_x_max_out (11) and hit_y_max_out (10).
- During SCAN it tracks the overlap bounding box: min/max dh and min/max dv over all ovl pixels.
- hit_x_out/hit_y_out become min x / min y, and the max ports give max x / max y. These are updated in REPORT only when colliding, and reset to 0.
- When not defined, the extra ports do not exist and hit_x/hit_y are the first-hit coordinates in raster order.

Decomposition:
- Package collision_pkg:
  - state enum {ARMED, SCAN, REPORT, LOCKED}
  - CNT_W=16
  - HCOUNT_W=11
  - VCOUNT_W=10
- Sub-module coord_delay: a parameterised depth/width shift register with a reset-cleared valid bit. It carries dh, dv and valid.

Test Plan:
- Reset released mid-frame at (500,300) → no frame_done_out until one full frame after the next (0,0); count=0; collision_out=0.
- 3 overlap pixels at (100..102,50), MIN_OVERLAP=4 → one frame_done_out pulse, overlap_count_out=3, collision_out=0, state back to ARMED.
- 10 overlap pixels starting at delayed (200,100) → frame_done_out and collision_out=1 on the cycle after (1279,719); hit=(200,100); count=10; held across later frames.
- Overlaps only at (1279,719) and 3 other active pixels, plus 5 in blanking (1300,10) → count=4, collision_out=1, blanking ignored.
- In LOCKED, pulse clear_in → collision_out=0 next cycle; next full frame with 0 overlaps yields frame_done_out with count=0. clear_in asserted on the last-pixel cycle aborts the frame with no pulse.
- enable_in=0 with full masks overlapping → count=0, no collision. With COLLISION_BBOX_EN, overlap rectangle (40..59,30..39) → hit_x_out=40, hit_y_out=30, hit_x_max_out=59, hit_y_max_out=39, count=200.

Source files
------------

// File: rtl/collision_pkg.sv
// Shared types and widths for the sprite collision detector.
package collision_pkg;

   typedef enum logic [1:0] {ARMED, SCAN, REPORT, LOCKED} state_t;

   localparam int CNT_W    = 16;
   localparam int HCOUNT_W = 11;
   localparam int VCOUNT_W = 10;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/coord_delay.sv
// Fixed-depth shift register for pixel coordinates, with a valid bit that
// fills with 1s after reset so cleared stages are never mistaken for data.
module coord_delay #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 21
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             valid
);

   localparam int PW = DEPTH * WIDTH;

   logic [PW-1:0]    pipe;
   logic [DEPTH-1:0] vpipe;

   // Whole-vector shifts keep DEPTH == 1 legal without special cases.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe  <= '0;
         vpipe <= '0;
      end else begin
         pipe  <= (pipe << WIDTH) | PW'(d);
         vpipe <= (vpipe << 1) | DEPTH'(1);
      end
   end

   assign q     = pipe[PW-1 -: WIDTH];
   assign valid = vpipe[DEPTH-1];

endmodule

// File: rtl/sprite_collision_detector.sv
// Per-frame player/obstacle overlap counter with sticky collision flag.
// Optional COLLISION_BBOX_EN reports the overlap bounding box instead of the first hit.
module sprite_collision_detector
   import collision_pkg::*;
#(
   parameter int SPRITE_LATENCY = 4,
   parameter int H_ACTIVE       = 1280,
   parameter int V_ACTIVE       = 720,
   parameter int MIN_OVERLAP    = 4
) (
   input  logic                pixel_clk_in,
   input  logic                rst_n_in,
   input  logic [HCOUNT_W-1:0] hcount_in,
   input  logic [VCOUNT_W-1:0] vcount_in,
   input  logic                player_draw_in,
   input  logic                obstacle_draw_in,
   input  logic                enable_in,
   input  logic                clear_in,
`ifdef COLLISION_BBOX_EN
   output logic [HCOUNT_W-1:0] hit_x_max_out,
   output logic [VCOUNT_W-1:0] hit_y_max_out,
`endif
   output logic                collision_out,
   output logic                frame_done_out,
   output logic [CNT_W-1:0]    overlap_count_out,
   output logic [HCOUNT_W-1:0] hit_x_out,
   output logic [VCOUNT_W-1:0] hit_y_out
);

   localparam logic [HCOUNT_W-1:0] H_END   = HCOUNT_W'(H_ACTIVE);
   localparam logic [VCOUNT_W-1:0] V_END   = VCOUNT_W'(V_ACTIVE);
   localparam logic [HCOUNT_W-1:0] H_LAST  = HCOUNT_W'(H_ACTIVE - 1);
   localparam logic [VCOUNT_W-1:0] V_LAST  = VCOUNT_W'(V_ACTIVE - 1);
   localparam logic [CNT_W-1:0]    MIN_CNT = CNT_W'(MIN_OVERLAP);

   logic [HCOUNT_W+VCOUNT_W-1:0] dcoord;
   logic [HCOUNT_W-1:0]          dh;
   logic [VCOUNT_W-1:0]          dv;
   logic                         valid;

   coord_delay #(.DEPTH(SPRITE_LATENCY), .WIDTH(HCOUNT_W + VCOUNT_W)) u_delay (
      .clk   (pixel_clk_in),
      .rst_n (rst_n_in),
      .d     ({hcount_in, vcount_in}),
      .q     (dcoord),
      .valid (valid)
   );

   assign dh = dcoord[HCOUNT_W+VCOUNT_W-1:VCOUNT_W];
   assign dv = dcoord[VCOUNT_W-1:0];

   logic active, ovl, first, last;
   assign active = valid && (dh < H_END) && (dv < V_END);
   assign ovl    = active && enable_in && player_draw_in && obstacle_draw_in;
   assign first  = valid && (dh == '0) && (dv == '0);
   assign last   = valid && (dh == H_LAST) && (dv == V_LAST);

   state_t state, state_nx;

   logic [CNT_W-1:0]    count, count_f;
   logic [HCOUNT_W-1:0] hx_lo, hx_lo_f;
   logic [VCOUNT_W-1:0] hy_lo, hy_lo_f;
`ifdef COLLISION_BBOX_EN
   logic [HCOUNT_W-1:0] hx_hi, hx_hi_f;
   logic [VCOUNT_W-1:0] hy_hi, hy_hi_f;
`endif
   logic collide, track_en, drop, report;

   // Frame totals including the current pixel; count==0 marks "no hit yet".
   always_comb begin
      count_f = ovl ? sat_inc(count) : count;
      hx_lo_f = hx_lo;
      hy_lo_f = hy_lo;
`ifdef COLLISION_BBOX_EN
      hx_hi_f = hx_hi;
      hy_hi_f = hy_hi;
`endif
      if (ovl) begin
         if (count == '0) begin
            hx_lo_f = dh;
            hy_lo_f = dv;
`ifdef COLLISION_BBOX_EN
            hx_hi_f = dh;
            hy_hi_f = dv;
         end else begin
            if (dh < hx_lo) hx_lo_f = dh;
            if (dv < hy_lo) hy_lo_f = dv;
            if (dh > hx_hi) hx_hi_f = dh;
            if (dv > hy_hi) hy_hi_f = dv;
`endif
         end
      end
   end

   assign collide = (count_f >= MIN_CNT);

   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) state <= ARMED;
      else           state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ARMED:   if (first) state_nx = SCAN;
         SCAN:    if (clear_in) state_nx = ARMED;
                  else if (last) state_nx = REPORT;
         REPORT:  state_nx = (clear_in || !collision_out) ? ARMED : LOCKED;
         LOCKED:  if (clear_in) state_nx = ARMED;
         default: state_nx = ARMED;
      endcase
   end

   always_comb begin
      track_en = ((state == ARMED) && first) || ((state == SCAN) && !clear_in);
      drop     = ((state == SCAN) && clear_in) || (state == REPORT);
      report   = (state == SCAN) && !clear_in && last;
   end

   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         count             <= '0;
         hx_lo             <= '0;
         hy_lo             <= '0;
         collision_out     <= 1'b0;
         frame_done_out    <= 1'b0;
         overlap_count_out <= '0;
         hit_x_out         <= '0;
         hit_y_out         <= '0;
`ifdef COLLISION_BBOX_EN
         hx_hi             <= '0;
         hy_hi             <= '0;
         hit_x_max_out     <= '0;
         hit_y_max_out     <= '0;
`endif
      end else begin
         frame_done_out <= report;
         if (track_en) begin
            count <= count_f;
            hx_lo <= hx_lo_f;
            hy_lo <= hy_lo_f;
`ifdef COLLISION_BBOX_EN
            hx_hi <= hx_hi_f;
            hy_hi <= hy_hi_f;
`endif
         end else if (drop) begin
            count <= '0;
            hx_lo <= '0;
            hy_lo <= '0;
`ifdef COLLISION_BBOX_EN
            hx_hi <= '0;
            hy_hi <= '0;
`endif
         end
         if (report) begin
            overlap_count_out <= count_f;
            if (collide) begin
               collision_out <= 1'b1;
               hit_x_out     <= hx_lo_f;
               hit_y_out     <= hy_lo_f;
`ifdef COLLISION_BBOX_EN
               hit_x_max_out <= hx_hi_f;
               hit_y_max_out <= hy_hi_f;
`endif
            end
         end
         // A clear during REPORT returns to ARMED, where the flag could never be dropped.
         if (((state == REPORT) || (state == LOCKED)) && clear_in)
            collision_out <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sprite_collision_detector.sv
// Scoreboard bench for sprite_collision_detector; masks/enable/clear are delayed
// in the bench to line up with the DUT's SPRITE_LATENCY coordinate pipeline.
module tb_sprite_collision_detector;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [10:0] hcount = '0;
   logic [9:0]  vcount = '0;
   logic        pdraw = 1'b0, odraw = 1'b0, en = 1'b0, clr = 1'b0;
   logic        collision, frame_done;
   logic [15:0] ocount;
   logic [10:0] hit_x;
   logic [9:0]  hit_y;
`ifdef COLLISION_BBOX_EN
   logic [10:0] hit_x_max;
   logic [9:0]  hit_y_max;
`endif

   sprite_collision_detector #(
      .SPRITE_LATENCY (4),
      .H_ACTIVE       (1280),
      .V_ACTIVE       (720),
      .MIN_OVERLAP    (4)
   ) dut (
      .pixel_clk_in      (clk),
      .rst_n_in          (rst_n),
      .hcount_in         (hcount),
      .vcount_in         (vcount),
      .player_draw_in    (pdraw),
      .obstacle_draw_in  (odraw),
      .enable_in         (en),
      .clear_in          (clr),
`ifdef COLLISION_BBOX_EN
      .hit_x_max_out     (hit_x_max),
      .hit_y_max_out     (hit_y_max),
`endif
      .collision_out     (collision),
      .frame_done_out    (frame_done),
      .overlap_count_out (ocount),
      .hit_x_out         (hit_x),
      .hit_y_out         (hit_y)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {bit p; bit o; bit e; bit c;} side_t;
   typedef struct {int unsigned cyc; int cnt; bit coll; int hx; int hy; int hxm; int hym;} exp_t;

   side_t       sideq[$];
   exp_t        sb[$];
   int          n_cmp = 0, n_bad = 0;
   int unsigned last_cyc = 0, frame_cyc = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Coordinates go out now; their masks/enable/clear go out 4 pixels later.
   task automatic px(input int h, input int v, input bit p, input bit o, input bit e, input bit c);
      side_t s;
      @(negedge clk);
      hcount   = 11'(h);
      vcount   = 10'(v);
      last_cyc = cyc;
      sideq.push_back('{p, o, e, c});
      s     = sideq.pop_front();
      pdraw = s.p;
      odraw = s.o;
      en    = s.e;
      clr   = s.c;
   endtask

   task automatic idle(input int h, input int v);
      px(h, v, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic hit(input int h, input int v);
      px(h, v, 1'b1, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic end_frame(input bit p, input bit o, input bit c);
      px(1279, 719, p, o, 1'b1, c);
      frame_cyc = last_cyc;
      idle(1290, 719);
      idle(1295, 719);
   endtask

   // Pulse is due one cycle after the DUT sees the last pixel: 4 delay + 1.
   task automatic expect_frame(input int cnt, input bit coll, input int hx, input int hy,
                               input int hxm, input int hym);
      exp_t e;
      e.cyc  = frame_cyc + 5;
      e.cnt  = cnt;
      e.coll = coll;
      e.hx   = hx;
      e.hy   = hy;
      e.hxm  = hxm;
      e.hym  = hym;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && frame_done) begin
         if (sb.size() == 0) begin
            chk("unexpected_frame_done", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("done_cycle", int'(cyc), int'(e.cyc));
            chk("overlap_count", int'(ocount), e.cnt);
            chk("collision", int'(collision), int'(e.coll));
            chk("hit_x", int'(hit_x), e.hx);
            chk("hit_y", int'(hit_y), e.hy);
`ifdef COLLISION_BBOX_EN
            chk("hit_x_max", int'(hit_x_max), e.hxm);
            chk("hit_y_max", int'(hit_y_max), e.hym);
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (4) sideq.push_back('{1'b0, 1'b0, 1'b0, 1'b0});

      // Reset held while the raster is mid-frame.
      for (int i = 0; i < 6; i++) idle(500 + i, 300);
      chk("rst_collision", int'(collision), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      chk("rst_count", int'(ocount), 0);
      chk("rst_hit_x", int'(hit_x), 0);
      chk("rst_hit_y", int'(hit_y), 0);
`ifdef COLLISION_BBOX_EN
      chk("rst_hit_x_max", int'(hit_x_max), 0);
      chk("rst_hit_y_max", int'(hit_y_max), 0);
`endif
      rst_n = 1'b1;
      for (int x = 506; x < 513; x++) hit(x, 300);
      end_frame(1'b1, 1'b1, 1'b0);                 // partial frame: no pulse

      idle(0, 0); idle(640, 360); end_frame(1'b0, 1'b0, 1'b0);
      expect_frame(0, 1'b0, 0, 0, 0, 0);

      // Below threshold.
      idle(0, 0); hit(100, 50); hit(101, 50); hit(102, 50);
      end_frame(1'b0, 1'b0, 1'b0);
      expect_frame(3, 1'b0, 0, 0, 0, 0);

      // Collision, then a LOCKED frame that must not report.
      idle(0, 0);
      for (int x = 200; x < 210; x++) hit(x, 100);
      end_frame(1'b0, 1'b0, 1'b0);
      expect_frame(10, 1'b1, 200, 100, 209, 100);
      idle(0, 0); for (int i = 0; i < 4; i++) hit(7 + i, 7);
      end_frame(1'b1, 1'b1, 1'b0);
      chk("locked_collision", int'(collision), 1);
      chk("locked_hit_x", int'(hit_x), 200);
      chk("locked_hit_y", int'(hit_y), 100);

      // Clear in LOCKED: flag drops on the cycle the DUT samples clear.
      px(1296, 719, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) idle(1297, 719);
      chk("collision_before_clear", int'(collision), 1);
      idle(1298, 719);
      chk("collision_after_clear", int'(collision), 0);

      idle(0, 0); end_frame(1'b0, 1'b0, 1'b0);
      expect_frame(0, 1'b0, 200, 100, 209, 100);

      // Clear on the last pixel aborts the frame.
      idle(0, 0); for (int i = 0; i < 5; i++) hit(10 + i, 10);
      end_frame(1'b1, 1'b1, 1'b1);
      idle(0, 0); end_frame(1'b0, 1'b0, 1'b0);
      expect_frame(0, 1'b0, 200, 100, 209, 100);

      // Last pixel counts; horizontal and vertical blanking do not.
      idle(0, 0);
      for (int x = 1300; x < 1305; x++) hit(x, 10);
      hit(3, 3); hit(4, 3); hit(5, 600); hit(5, 730);
      end_frame(1'b1, 1'b1, 1'b0);
`ifdef COLLISION_BBOX_EN
      expect_frame(4, 1'b1, 3, 3, 1279, 719);
`else
      expect_frame(4, 1'b1, 3, 3, 0, 0);
`endif
      px(1296, 719, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) idle(1297, 719);

      // Enable low masks every overlap.
      idle(0, 0);
      for (int x = 0; x < 10; x++) px(x, 20, 1'b1, 1'b1, 1'b0, 1'b0);
      end_frame(1'b0, 1'b0, 1'b0);
`ifdef COLLISION_BBOX_EN
      expect_frame(0, 1'b0, 3, 3, 1279, 719);
`else
      expect_frame(0, 1'b0, 3, 3, 0, 0);
`endif

      // Overlap rectangle (40..59, 30..39).
      idle(0, 0);
      for (int y = 30; y < 40; y++)
         for (int x = 40; x < 60; x++) hit(x, y);
      end_frame(1'b0, 1'b0, 1'b0);
      expect_frame(200, 1'b1, 40, 30, 59, 39);

      for (int i = 0; i < 8; i++) idle(1300, 719);
      chk("scoreboard_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
